queue_occupancy_tracker: RTL

Keeps one saturating occupancy counter per queue ID in a dual-port block RAM and applies a stream of signed deltas to it, one per cycle, by read-modify-write. Sits beside the enqueue/dequeue schedulers in the queueing datapath. After every reset it clears all counters, then reports each updated value for threshold and drop decisions downstream.

---
 rtl/queue_occupancy_tracker_pkg.sv | 11 +
 rtl/queue_occupancy_tracker_dualport_bram.sv | 33 +++
 rtl/queue_occupancy_tracker.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/queue_occupancy_tracker_pkg.sv
// Shared types for the queue occupancy tracker.
// Holds the INIT/RUN state encoding used by the tracker FSM.
// No logic lives here; the width-dependent constants stay in the top module.
package queue_occupancy_tracker_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } qot_state_e;

endpackage

// File: rtl/queue_occupancy_tracker_dualport_bram.sv
// Dual-port block RAM: port A read/write with registered read, port B write-only.
// Latency: read data on a_dout_o one cycle after a_addr_i is sampled (read-first on collisions).
// No backpressure; every port operation completes in one cycle.
// Ports: clk_i; a_we_i/a_addr_i/a_din_i/a_dout_o; b_we_i/b_addr_i/b_din_i.
module dualport_bram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  a_we_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [DATA_WIDTH-1:0] a_din_i,
    output logic [DATA_WIDTH-1:0] a_dout_o,
    input  logic                  b_we_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [DATA_WIDTH-1:0] b_din_i
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Single process so the array has one driver. The read uses the pre-edge
    // contents, so a same-address write on either port returns the old word.
    always_ff @(posedge clk_i) begin
        if (a_we_i) begin
            mem[a_addr_i] <= a_din_i;
        end
        if (b_we_i) begin
            mem[b_addr_i] <= b_din_i;
        end
        a_dout_o <= mem[a_addr_i];
    end

endmodule

// File: rtl/queue_occupancy_tracker.sv
// Per-queue saturating occupancy counters in BRAM, updated by signed deltas via read-modify-write.
// Latency: request driven in cycle T is accepted at edge T+1; result and RAM write land at edge T+2.
// Backpressure: upd_ready_o low only while the post-reset clear sweep runs; one update per cycle in RUN.
// Ports: upd_valid_i/upd_ready_o/upd_qid_i/upd_delta_i request side; res_valid_o/res_qid_o/res_cnt_o/
//        res_sat_o result side; init_done_o marks the end of the clear sweep.
module queue_occupancy_tracker
    import queue_occupancy_tracker_pkg::*;
#(
    parameter int QID_WIDTH   = 8,
    parameter int CNT_WIDTH   = 32,
    parameter int DELTA_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   upd_valid_i,
    output logic                   upd_ready_o,
    input  logic [QID_WIDTH-1:0]   upd_qid_i,
    input  logic [DELTA_WIDTH-1:0] upd_delta_i,
    output logic                   res_valid_o,
    output logic [QID_WIDTH-1:0]   res_qid_o,
    output logic [CNT_WIDTH-1:0]   res_cnt_o,
    output logic                   res_sat_o,
    output logic                   init_done_o
);

    localparam int                   DEPTH     = 2**QID_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [QID_WIDTH-1:0] LAST_ADDR = QID_WIDTH'(DEPTH - 1);
    // Two extra bits: one for carry past CNT_MAX, one for the sign.
    localparam int                   SUM_WIDTH = CNT_WIDTH + 2;

    qot_state_e             state_q, state_d;
    logic [QID_WIDTH-1:0]   sweep_q, sweep_d;
    logic                   sweep_arm_q;

    logic                   s1_vld_q;
    logic [QID_WIDTH-1:0]   s1_qid_q;
    logic [DELTA_WIDTH-1:0] s1_delta_q;

    logic                   fwd_vld_q;
    logic [QID_WIDTH-1:0]   fwd_qid_q;
    logic [CNT_WIDTH-1:0]   fwd_cnt_q;

    logic                   res_vld_q;
    logic [QID_WIDTH-1:0]   res_qid_q;
    logic [CNT_WIDTH-1:0]   res_cnt_q;
    logic                   res_sat_q;

    logic                   accept;
    logic [CNT_WIDTH-1:0]   ram_a_dout;
    logic [CNT_WIDTH-1:0]   old_cnt;
    logic [CNT_WIDTH-1:0]   new_cnt;
    logic                   new_sat;
    logic signed [SUM_WIDTH-1:0] sum;

    logic                   b_we;
    logic [QID_WIDTH-1:0]   b_addr;
    logic [CNT_WIDTH-1:0]   b_din;

    assign accept = upd_valid_i && (state_q == ST_RUN);

    dualport_bram #(
        .ADDR_WIDTH (QID_WIDTH),
        .DATA_WIDTH (CNT_WIDTH)
    ) u_ram (
        .clk_i    (clk_i),
        .a_we_i   (1'b0),
        .a_addr_i (upd_qid_i),
        .a_din_i  ('0),
        .a_dout_o (ram_a_dout),
        .b_we_i   (b_we),
        .b_addr_i (b_addr),
        .b_din_i  (b_din)
    );

    // Saturating add. A back-to-back update to the same queue read the RAM while
    // the previous result was still being written (read-first returns stale data),
    // so the previous write is taken from the forward register instead.
    always_comb begin
        old_cnt = ram_a_dout;
        if (fwd_vld_q && (fwd_qid_q == s1_qid_q)) begin
            old_cnt = fwd_cnt_q;
        end
        sum = $signed({2'b00, old_cnt})
            + $signed({{(SUM_WIDTH-DELTA_WIDTH){s1_delta_q[DELTA_WIDTH-1]}}, s1_delta_q});
        new_cnt = sum[CNT_WIDTH-1:0];
        new_sat = 1'b0;
        if (sum[SUM_WIDTH-1]) begin
            new_cnt = '0;
            new_sat = 1'b1;
        end else if (sum[CNT_WIDTH]) begin
            new_cnt = CNT_MAX;
            new_sat = 1'b1;
        end
    end

    // FSM and port-B ownership: the sweep owns port B in INIT, S1 in RUN.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        b_we    = 1'b0;
        b_addr  = s1_qid_q;
        b_din   = new_cnt;
        case (state_q)
            ST_INIT: begin
                b_addr = sweep_q;
                b_din  = '0;
                // sweep_arm_q holds the sweep for the first edge after reset release,
                // so address 0 is written in the cycle after reset is seen high.
                if (sweep_arm_q) begin
                    b_we    = 1'b1;
                    sweep_d = sweep_q + QID_WIDTH'(1);
                    if (sweep_q == LAST_ADDR) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // An in-flight result is dropped when reset arrives.
                b_we = s1_vld_q && rst_n_i;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_INIT;
            sweep_q     <= '0;
            sweep_arm_q <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_qid_q    <= '0;
            s1_delta_q  <= '0;
            fwd_vld_q   <= 1'b0;
            fwd_qid_q   <= '0;
            fwd_cnt_q   <= '0;
            res_vld_q   <= 1'b0;
            res_qid_q   <= '0;
            res_cnt_q   <= '0;
            res_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            sweep_arm_q <= 1'b1;
            s1_vld_q    <= accept;
            if (accept) begin
                s1_qid_q   <= upd_qid_i;
                s1_delta_q <= upd_delta_i;
            end
            fwd_vld_q <= s1_vld_q;
            fwd_qid_q <= s1_qid_q;
            fwd_cnt_q <= new_cnt;
            res_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                res_qid_q <= s1_qid_q;
                res_cnt_q <= new_cnt;
                res_sat_q <= new_sat;
            end
        end
    end

    assign upd_ready_o = (state_q == ST_RUN);
    assign init_done_o = (state_q == ST_RUN);
    assign res_valid_o = res_vld_q;
    assign res_qid_o   = res_qid_q;
    assign res_cnt_o   = res_cnt_q;
    assign res_sat_o   = res_sat_q;

endmodule
